div_result_bcd: RTL and testbench

- Sequential signed binary-to-BCD converter placed directly downstream of the algorithmic divider.
- Takes a two's-complement quotient or remainder word plus a start strobe, normally the divider's Done pulse.
- Produces a sign flag and NDIG packed BCD digits for the display driver, using shift-and-add-3 (double dabble), one bit per two cycles.
- Start/Done pulse handshake, same style as the divider.

---
 rtl/div_pkg.sv | 22 ++
 rtl/bcd_add3.sv | 14 +
 rtl/div_result_bcd.sv | 122 ++++++++++++
 tb/tb_div_result_bcd.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the divider result path
package div_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_ADJ   = 2'd1,
    BCD_SHIFT = 2'd2,
    BCD_FIN   = 2'd3
  } bcd_state_t;

  // Display driver code for an unlit digit position
  localparam bcd_digit_t BCD_BLANK = 4'hF;

  // Smallest digit count n with 10^n > 2^width, using floor(width*log10(2))+1;
  // a power of two is never a power of ten, so the floor form is exact
  function automatic int ndig_for(input int width);
    return ((width * 30103) / 100000) + 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction, +3 when the digit is 5 or more
import div_pkg::*;

module bcd_add3 (
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // Correct a digit before the next shift so it carries into the next decade
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/div_result_bcd.sv
// rtl/div_result_bcd.sv - signed binary to packed BCD converter; BCD_LEADING_ZERO_BLANK_EN blanks leading zeros
import div_pkg::*;

module div_result_bcd #(
  parameter int tamanyo   = 32,
  parameter int NDIG      = ndig_for(tamanyo),
  parameter int SIGNED_IN = 1
) (
  input  logic                CLK,
  input  logic                RSTa,
  input  logic                Start,
  input  logic [tamanyo-1:0]  Bin,
  output logic                Neg,
  output logic [4*NDIG-1:0]   Digits,
  output logic                Busy,
  output logic                Done
);

  localparam int CNTW = $clog2(tamanyo);

  bcd_state_t              state;
  bcd_state_t              state_nx;
  logic [tamanyo-1:0]      mag;
  logic [4*NDIG-1:0]       bcd;
  logic [4*NDIG-1:0]       bcd_adj;
  logic [4*NDIG-1:0]       digits_fmt;
  logic [CNTW-1:0]         cnt;
  logic                    neg_int;

  // One corrector per digit; all digits are adjusted in the same cycle
  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (bcd[4*g +: 4]),
        .dout (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) state <= BCD_IDLE;
    else       state <= state_nx;
  end

  // Next-state: one adjust plus one shift per input bit, then a single finish cycle
  always_comb begin
    state_nx = state;
    case (state)
      BCD_IDLE:  if (Start) state_nx = BCD_ADJ;
      BCD_ADJ:   state_nx = BCD_SHIFT;
      BCD_SHIFT: state_nx = (cnt == '0) ? BCD_FIN : BCD_ADJ;
      BCD_FIN:   state_nx = BCD_IDLE;
      default:   state_nx = BCD_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    Busy = (state != BCD_IDLE);
  end

  // Conversion datapath: capture magnitude, adjust, shift
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      mag     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      neg_int <= 1'b0;
    end else begin
      case (state)
        BCD_IDLE: begin
          if (Start) begin
            // ~Bin+1 kept at tamanyo bits so the most negative value maps to 2^(tamanyo-1)
            neg_int <= (SIGNED_IN != 0) && Bin[tamanyo-1];
            mag     <= ((SIGNED_IN != 0) && Bin[tamanyo-1]) ? (~Bin + 1'b1) : Bin;
            bcd     <= '0;
            cnt     <= CNTW'(tamanyo - 1);
          end
        end
        BCD_ADJ: bcd <= bcd_adj;
        BCD_SHIFT: begin
          {bcd, mag} <= {bcd[4*NDIG-2:0], mag, 1'b0};
          cnt        <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Final digit formatting, optionally replacing leading zeros with the blank code
  always_comb begin
    digits_fmt = bcd;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    begin : blank_scan
      logic seen;
      seen = 1'b0;
      for (int i = NDIG - 1; i >= 1; i--) begin
        if (bcd[4*i +: 4] != 4'd0) seen = 1'b1;
        else if (!seen)            digits_fmt[4*i +: 4] = BCD_BLANK;
      end
    end
`endif
  end

  // Result registers only change at FIN so the display never sees partial values
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      Neg    <= 1'b0;
      Digits <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= (state == BCD_FIN);
      if (state == BCD_FIN) begin
        Neg    <= neg_int;
        Digits <= digits_fmt;
      end
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// tb/tb_div_result_bcd.sv - self-checking bench for div_result_bcd against a decimal reference model
module tb_div_result_bcd;

  localparam int W  = 32;
  localparam int ND = 10;

  logic            CLK;
  logic            RSTa;
  logic            Start;
  logic [W-1:0]    Bin;
  logic            Neg;
  logic [4*ND-1:0] Digits;
  logic            Busy;
  logic            Done;

  int errors = 0;
  int checks = 0;

  div_result_bcd #(.tamanyo(W), .NDIG(ND), .SIGNED_IN(1)) dut (
    .CLK    (CLK),
    .RSTa   (RSTa),
    .Start  (Start),
    .Bin    (Bin),
    .Neg    (Neg),
    .Digits (Digits),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: sign and magnitude from plain arithmetic, digits by repeated /10
  function automatic logic ref_neg(input logic [W-1:0] b);
    return b[W-1];
  endfunction

  function automatic logic [4*ND-1:0] ref_digits(input logic [W-1:0] b);
    longint m;
    logic [4*ND-1:0] d;
    logic seen;
    m = b[W-1] ? -longint'($signed(b)) : longint'(b);
    d = '0;
    for (int i = 0; i < ND; i++) begin
      d[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
`ifdef BCD_LEADING_ZERO_BLANK_EN
    seen = 1'b0;
    for (int i = ND - 1; i >= 1; i--) begin
      if (d[4*i +: 4] != 4'd0) seen = 1'b1;
      else if (!seen)          d[4*i +: 4] = 4'hF;
    end
`else
    seen = 1'b0;
`endif
    return d;
  endfunction

  // Present Start/Bin for one rising edge; caller is #1 past an edge
  task automatic launch(input logic [W-1:0] b);
    Start = 1'b1;
    Bin   = b;
    @(posedge CLK);
    #1;
    Start = 1'b0;
  endtask

  // Walk 65 edges after the sampling edge, checking timing and held outputs
  task automatic wait_done(input string tag, input logic [W-1:0] b);
    logic early;
    logic moved;
    logic [4*ND-1:0] prev;
    early = 1'b0;
    moved = 1'b0;
    prev  = Digits;
    for (int k = 1; k <= 2*W + 1; k++) begin
      @(posedge CLK);
      #1;
      if (k < 2*W + 1) begin
        if (Done)           early = 1'b1;
        if (Digits !== prev) moved = 1'b1;
      end
      if (k == 10) check({tag, "_busy"}, 64'(Busy), 64'd1);
    end
    check({tag, "_no_early_done"}, 64'(early), 64'd0);
    check({tag, "_digits_held"},   64'(moved), 64'd0);
    check({tag, "_done"},          64'(Done),  64'd1);
    check({tag, "_neg"},           64'(Neg),   64'(ref_neg(b)));
    check({tag, "_digits"},        64'(Digits), 64'(ref_digits(b)));
  endtask

  // Count Done pulses over a fixed window
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge CLK);
      #1;
      if (Done) n++;
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] b;
    logic [4*ND-1:0] d12345;

    RSTa  = 1'b0;
    Start = 1'b0;
    Bin   = '0;
    repeat (2) @(posedge CLK);
    #1;
    RSTa = 1'b1;

    // Reset state, idle with no Start
    count_done(5, n);
    check("idle_done_count", 64'(n), 64'd0);
    check("reset_neg",    64'(Neg),    64'd0);
    check("reset_digits", 64'(Digits), 64'd0);
    check("reset_busy",   64'(Busy),   64'd0);

    // Directed values
    launch(32'd12345);
    wait_done("v12345", 32'd12345);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    d12345 = 40'hFFFFF12345;
`else
    d12345 = 40'h0000012345;
`endif
    check("v12345_literal", 64'(Digits), 64'(d12345));

    launch(-32'sd7);
    wait_done("vminus7", -32'sd7);

    launch(32'h80000000);
    wait_done("vmostneg", 32'h80000000);
    check("vmostneg_literal", 64'(Digits), 64'h2147483648);

    launch(32'd0);
    wait_done("vzero", 32'd0);
    check("vzero_units", 64'(Digits[3:0]), 64'd0);

    launch(32'hFFFFFFFF);
    wait_done("vminus1", 32'hFFFFFFFF);
    launch(32'h7FFFFFFF);
    wait_done("vmostpos", 32'h7FFFFFFF);

    // Start mid-conversion is ignored
    launch(32'd4321);
    repeat (9) @(posedge CLK);
    #1;
    launch(32'd8888);
    b = 32'd4321;
    count_done(55, n);
    check("ignored_done_count", 64'(n), 64'd1);
    check("ignored_digits", 64'(Digits), 64'(ref_digits(b)));
    count_done(70, n);
    check("ignored_no_second_done", 64'(n), 64'd0);

    // Asynchronous reset mid-conversion
    launch(32'd55555);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    RSTa = 1'b0;
    #1;
    check("abort_neg",    64'(Neg),    64'd0);
    check("abort_digits", 64'(Digits), 64'd0);
    check("abort_busy",   64'(Busy),   64'd0);
    check("abort_done",   64'(Done),   64'd0);
    @(negedge CLK);
    RSTa = 1'b1;
    count_done(70, n);
    check("abort_no_done", 64'(n), 64'd0);
    launch(32'd999);
    wait_done("after_abort_999", 32'd999);

    // Back-to-back: Start accepted in the Done cycle
    launch(32'd77);
    wait_done("b2b_first", 32'd77);
    launch(32'd100);
    wait_done("b2b_second", 32'd100);

    // Random values, mixing full-range and small signed magnitudes
    for (int r = 0; r < 16; r++) begin
      b = $urandom;
      if (r % 3 == 0) b = W'($urandom_range(0, 999));
      if (r % 4 == 1) b = -$signed(W'($urandom_range(0, 99999)));
      launch(b);
      wait_done($sformatf("rand%0d", r), b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
